// File: rtl/tt_uio_gpio_pkg.sv
// tt_uio_gpio_pkg: register map constants shared by the GPIO block and its users
package tt_uio_gpio_pkg;
  localparam int NUM_REGS = 8;
  localparam logic [2:0] ADDR_DIR      = 3'd0;
  localparam logic [2:0] ADDR_OUT      = 3'd1;
  localparam logic [2:0] ADDR_IN       = 3'd2;
  localparam logic [2:0] ADDR_FLAGS    = 3'd3;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd4;
  localparam logic [2:0] ADDR_EDGE_POL = 3'd5;
  localparam logic [2:0] ADDR_EDGE_ANY = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;
endpackage

// File: rtl/tt_sync_ff.sv
// tt_sync_ff: multi-flop synchroniser bringing asynchronous pad inputs into the clk domain
module tt_sync_ff #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sr;
  // shift the raw input through STAGES flops; the last stage is the synchronised value
  always_ff @(posedge clk)
    if (!rst_n) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/tt_uio_gpio.sv
// tt_uio_gpio: bidirectional GPIO bank with edge-flag interrupts and a small register bus
module tt_uio_gpio
  import tt_uio_gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe,
  output logic             irq
);
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);
  logic [WIDTH-1:0] dir, out, flags, irq_en, edge_pol, edge_any;
  logic [WIDTH-1:0] in_sync, in_prev, rise, fall, edges, w1c, rd_mux;
  logic [2:0] prime;
  logic primed;
  tt_sync_ff #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (uio_in),
    .q    (in_sync)
  );
  assign uio_oe  = dir;
  assign uio_out = out;
  assign irq     = |(flags & irq_en);
  assign primed  = prime == PRIME_MAX;
  assign rise    = in_sync & ~in_prev;
  assign fall    = ~in_sync & in_prev;
  assign edges   = primed ? ~dir & ((edge_any & (rise | fall)) | (~edge_any & (edge_pol & fall | ~edge_pol & rise))) : '0;
  assign w1c     = (wr_en && addr == ADDR_FLAGS) ? wdata : '0;
  // history flop for edge detection and the post-reset prime counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      in_prev <= '0;
      prime   <= '0;
    end else begin
      in_prev <= in_sync;
      prime   <= primed ? prime : prime + 3'd1;
    end
  // CPU-writable control registers, frozen while the block is disabled
  always_ff @(posedge clk)
    if (!rst_n) begin
      dir      <= '0;
      out      <= '0;
      irq_en   <= '0;
      edge_pol <= '0;
      edge_any <= '0;
    end else if (ena && wr_en) begin
      case (addr)
        ADDR_DIR:      dir      <= wdata;
        ADDR_OUT:      out      <= wdata;
        ADDR_IRQ_EN:   irq_en   <= wdata;
        ADDR_EDGE_POL: edge_pol <= wdata;
        ADDR_EDGE_ANY: edge_any <= wdata;
        default: ;
      endcase
    end
  // edge flags: a new edge outranks a simultaneous write-1-to-clear
  always_ff @(posedge clk)
    if (!rst_n) flags <= '0;
    else if (ena) flags <= (flags & ~w1c) | edges;
  // read mux over the pre-write register values
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_DIR:      rd_mux = dir;
      ADDR_OUT:      rd_mux = out;
      ADDR_IN:       rd_mux = in_sync;
      ADDR_FLAGS:    rd_mux = flags;
      ADDR_IRQ_EN:   rd_mux = irq_en;
      ADDR_EDGE_POL: rd_mux = edge_pol;
      ADDR_EDGE_ANY: rd_mux = edge_any;
      ADDR_RSVD:     rd_mux = '0;
      default:       rd_mux = '0;
    endcase
  end
  // registered read data, held while no read is requested
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
endmodule

// File: tb/tb_tt_uio_gpio.sv
// tb_tt_uio_gpio: directed self-checking bench for the GPIO block
module tb_tt_uio_gpio;
  logic clk, rst_n, ena, wr_en, rd_en, irq;
  logic [2:0] addr;
  logic [7:0] wdata, rdata, uio_in, uio_out, uio_oe;
  int checks, failures;
  tt_uio_gpio dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .addr   (addr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wdata  (wdata),
    .rdata  (rdata),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .irq    (irq)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a;
    wdata = d;
    wr_en = 1;
    tick();
    wr_en = 0;
  endtask
  task automatic rd(input logic [2:0] a);
    addr = a;
    rd_en = 1;
    tick();
    rd_en = 0;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0; ena = 1; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; uio_in = 8'hFF;
    tick(2);
    chk("rst_oe", uio_oe, 8'h00);
    chk("rst_out", uio_out, 8'h00);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1;
    tick(10);
    rd(3); chk("prime_flags", rdata, 8'h00);
    rd(2); chk("in_high", rdata, 8'hFF);
    uio_in = 8'h00;
    tick(4);
    rd(3); chk("fall_no_flag", rdata, 8'h00);
    wr(0, 8'hF0); chk("dir_oe", uio_oe, 8'hF0);
    wr(1, 8'hA5); chk("out_pins", uio_out, 8'hA5);
    rd(1); chk("rd_out", rdata, 8'hA5);
    tick(2); chk("rdata_hold", rdata, 8'hA5);
    addr = 1; wdata = 8'h3C; wr_en = 1; rd_en = 1;
    tick();
    wr_en = 0; rd_en = 0;
    chk("rw_prewrite", rdata, 8'hA5);
    chk("rw_written", uio_out, 8'h3C);
    wr(7, 8'hFF); rd(7); chk("rsvd_zero", rdata, 8'h00);
    wr(2, 8'hFF); rd(2); chk("in_ro", rdata, 8'h00);
    wr(0, 8'h00);
    wr(4, 8'h01);
    uio_in = 8'h01;
    tick(2); chk("irq_n2", irq, 0);
    tick(); chk("irq_n3", irq, 1);
    rd(3); chk("flag_rise", rdata, 8'h01);
    wr(3, 8'h01); chk("irq_cleared", irq, 0);
    wr(4, 8'h00);
    wr(5, 8'h02);
    wr(6, 8'h04);
    uio_in = 8'h07; tick(4);
    rd(3); chk("pol_rise", rdata, 8'h04);
    wr(3, 8'h04);
    uio_in = 8'h01; tick(4);
    rd(3); chk("pol_fall", rdata, 8'h06);
    wr(3, 8'h06);
    wr(0, 8'h08);
    uio_in = 8'h09; tick(4);
    uio_in = 8'h01; tick(4);
    rd(3); chk("out_pin_noflag", rdata, 8'h00);
    wr(0, 8'h00);
    wr(5, 8'h00); wr(6, 8'h00);
    uio_in = 8'h00; tick(4);
    uio_in = 8'h01; tick(4);
    rd(3); chk("coll_pre", rdata, 8'h01);
    uio_in = 8'h00; tick(4);
    uio_in = 8'h01; tick(2);
    wr(3, 8'h01);
    rd(3); chk("collision", rdata, 8'h01);
    wr(3, 8'h01);
    rd(3); chk("w1c_plain", rdata, 8'h00);
    ena = 0;
    wr(0, 8'hFF);
    chk("ena_oe", uio_oe, 8'h00);
    rd(0); chk("ena_dir", rdata, 8'h00);
    uio_in = 8'h00; tick(2);
    rd(2); chk("ena_in", rdata, 8'h00);
    uio_in = 8'h01; tick(4);
    rd(3); chk("ena_flags", rdata, 8'h00);
    ena = 1;
    wr(4, 8'h01);
    uio_in = 8'h00; tick(4);
    uio_in = 8'h01; tick(4);
    rd(3); chk("pre_rst_flag", rdata, 8'h01);
    chk("pre_rst_irq", irq, 1);
    rst_n = 0; tick();
    chk("midrst_rdata", rdata, 8'h00);
    chk("midrst_irq", irq, 0);
    rst_n = 1;
    tick(10);
    rd(3); chk("midrst_flags", rdata, 8'h00);
    rd(4); chk("midrst_irqen", rdata, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
